// File: rtl/fetch_unit_pkg.sv
// Shared state encodings for the fetch unit and the helper that decodes
// which states consume a byte from the program counter.
package fetch_unit_pkg;

  typedef enum logic [4:0] {
    S_RESET           = 5'd0,
    S_FETCH_1         = 5'd1,
    S_FETCH_2         = 5'd2,
    S_FETCH_IMMEDIATE = 5'd3,
    S_FETCH_ADDRESS_1 = 5'd4,
    S_FETCH_ADDRESS_2 = 5'd5,
    S_FETCH_ADDRESS_3 = 5'd6,
    S_FETCH_ADDRESS_4 = 5'd7,
    S_LOAD_JUMP_1     = 5'd8,
    S_LOAD_JUMP_2     = 5'd9,
    S_EXECUTE_JUMP    = 5'd10,
    S_FETCH_MEMORY    = 5'd11,
    S_STORE_MEMORY    = 5'd12,
    S_TEMP_FETCH      = 5'd13,
    S_TEMP_STORE      = 5'd14,
    S_ALU             = 5'd15,
    S_STORE_RESULT    = 5'd16,
    S_COPY_REGISTER   = 5'd17,
    S_HALT            = 5'd18
  } state_e;

  // The nine byte-fetch states each read mem[pc] and advance pc by one.
  function automatic logic is_consume(input state_e s);
    return s inside {S_FETCH_1, S_FETCH_2, S_FETCH_IMMEDIATE,
                     S_FETCH_ADDRESS_1, S_FETCH_ADDRESS_2,
                     S_FETCH_ADDRESS_3, S_FETCH_ADDRESS_4,
                     S_LOAD_JUMP_1, S_LOAD_JUMP_2};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Program counter, instruction/operand registers and memory-address sequencer
// driven by the control FSM's state code; big-endian byte assembly.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int RESET_VECTOR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        state,
  input  logic [7:0]        mem_rdata,
  input  logic [7:0]        reg_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic [15:0]       instruction,
  output logic [7:0]        immediate,
  output logic [ADDR_W-1:0] operand_addr,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR);

  state_e            st;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       instr_q;
  logic [7:0]        imm_q;
  logic [7:0]        temp_q;
  logic [15:0]       addr_a_q;
  logic [15:0]       addr_b_q;
  logic [15:0]       jump_q;

  // Undefined codes fall through to the hold/default branches below.
  assign st = state_e'(state);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      imm_q    <= '0;
      temp_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      jump_q   <= '0;
    end else if (st == S_RESET) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      imm_q    <= '0;
      temp_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      jump_q   <= '0;
    end else begin
      if (is_consume(st)) pc_q <= pc_q + ADDR_W'(1);
      case (st)
        S_FETCH_1:         instr_q[15:8]  <= mem_rdata;
        S_FETCH_2:         instr_q[7:0]   <= mem_rdata;
        S_FETCH_IMMEDIATE: imm_q          <= mem_rdata;
        S_FETCH_ADDRESS_1: addr_a_q[15:8] <= mem_rdata;
        S_FETCH_ADDRESS_2: addr_a_q[7:0]  <= mem_rdata;
        S_FETCH_ADDRESS_3: addr_b_q[15:8] <= mem_rdata;
        S_FETCH_ADDRESS_4: addr_b_q[7:0]  <= mem_rdata;
        S_LOAD_JUMP_1:     jump_q[15:8]   <= mem_rdata;
        S_LOAD_JUMP_2:     jump_q[7:0]    <= mem_rdata;
        S_EXECUTE_JUMP:    pc_q           <= jump_q[ADDR_W-1:0];
        S_TEMP_FETCH:      temp_q         <= mem_rdata;
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    mem_addr  = pc_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (st)
      S_FETCH_MEMORY,
      S_TEMP_FETCH: mem_addr = addr_a_q[ADDR_W-1:0];
      S_STORE_MEMORY: begin
        mem_addr  = addr_a_q[ADDR_W-1:0];
        mem_we    = 1'b1;
        mem_wdata = reg_wdata;
      end
      S_TEMP_STORE: begin
        mem_addr  = addr_b_q[ADDR_W-1:0];
        mem_we    = 1'b1;
        mem_wdata = temp_q;
      end
      default: ;
    endcase
  end

  assign pc           = pc_q;
  assign instruction  = instr_q;
  assign immediate    = imm_q;
  assign operand_addr = addr_a_q[ADDR_W-1:0];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program counter, instruction register and memory-address sequencer that sits directly upstream of the control FSM.
- Consumes the FSM's 5-bit state code.
- Drives the byte-wide memory port.
- Assembles the 16-bit instruction and the operand bytes (immediate, operand addresses, jump target) that the control FSM and datapath consume.
- Performs the two-address MOVE transfer through an internal temp byte.

Parameters:
ADDR_W, 16, memory address width; PC and address registers are ADDR_W bits.
RESET_VECTOR, 0, PC value after reset and while in S_RESET.

Ports:
clock  in  1  system clock, all state updates on posedge.
reset  in  1  asynchronous, active-low; 0 clears all registers immediately.
state  in  5  control FSM state code (S_* encodings from constants.v).
mem_rdata  in  8  memory read data, combinational from mem_addr, valid within the same cycle.
reg_wdata  in  8  register-file byte to be written during S_STORE_MEMORY.
mem_addr  out  ADDR_W  memory address, combinational from state and registers.
mem_we  out  1  memory write strobe, combinational.
mem_wdata  out  8  memory write data.
instruction  out  16  instruction register.
immediate  out  8  immediate operand register.
operand_addr  out  ADDR_W  first operand address register (addr_a).
pc  out  ADDR_W  program counter.

Behaviour:
- Reset (reset==0, asynchronous): pc=RESET_VECTOR; instruction, immediate, addr_a, addr_b, jump_target and temp all 0.
- While state==S_RESET: the same values are loaded synchronously.
- Byte order is big-endian: the first byte fetched is the high byte.
- Each rdata capture happens at the posedge that ends the named state.
- Per-state actions ("consume" means pc<=pc+1, wrapping modulo 2^ADDR_W):
  - S_FETCH_1: mem_addr=pc; instruction[15:8]<=mem_rdata; consume.
  - S_FETCH_2: mem_addr=pc; instruction[7:0]<=mem_rdata; consume. The FSM decodes instruction[15:11] during this state, so the high byte must already be registered when S_FETCH_2 begins.
  - S_FETCH_IMMEDIATE: mem_addr=pc; immediate<=mem_rdata; consume.
  - S_FETCH_ADDRESS_1 / _2: mem_addr=pc; addr_a high / low byte <= mem_rdata; consume.
  - S_FETCH_ADDRESS_3 / _4: mem_addr=pc; addr_b high / low byte <= mem_rdata; consume.
  - S_LOAD_JUMP_1 / _2: mem_addr=pc; jump_target high / low byte <= mem_rdata; consume.
  - S_EXECUTE_JUMP: pc<=jump_target[ADDR_W-1:0]; mem_addr=pc; no read capture.
  - S_FETCH_MEMORY: mem_addr=addr_a; data goes to the datapath; pc unchanged.
  - S_STORE_MEMORY: mem_addr=addr_a; mem_we=1; mem_wdata=reg_wdata.
  - S_TEMP_FETCH: mem_addr=addr_a; temp<=mem_rdata.
  - S_TEMP_STORE: mem_addr=addr_b; mem_we=1; mem_wdata=temp.
  - All other states (ALU, STORE_RESULT, COPY_REGISTER, HALT, undefined codes): mem_addr=pc; mem_we=0; all registers hold.
- mem_we is 1 only in S_STORE_MEMORY and S_TEMP_STORE.
- mem_wdata is 0 when mem_we is 0.
- Jump target and address bytes are assembled as 16 bits; bits above ADDR_W are discarded.
- PC wrap: pc = 2^ADDR_W-1 followed by a consume gives 0, with no flag.
- Reset asserted mid-instruction: registers clear the same cycle; partial fetches are discarded.
- S_HALT: pc and all registers frozen indefinitely.

Decomposition:
- S_* state encodings and opcode constants stay in the shared constants.v; no new constants are added there.
- A local function or wire decodes "consume" = state is one of the nine byte-fetch states.
- No sub-module is required; the block is one flat always_ff plus combinational address/write muxes.

Test Plan:
- Reset while pc=0x0042: reset=0 -> pc=0, instruction=0, mem_we=0 asynchronously, without waiting for a clock edge.
- Memory[0]=0xA8, [1]=0x05; state FETCH_1 then FETCH_2 -> instruction=0xA805, pc=2; during FETCH_2 instruction[15:8]=0xA8.
- Jump: memory[2]=0x12, [3]=0x34; states LOAD_JUMP_1, LOAD_JUMP_2, EXECUTE_JUMP -> pc=0x1234 after EXECUTE_JUMP, and mem_addr=0x1234 in the next FETCH_1.
- MOVE:
  - Stimulus: addr bytes 0x00,0x80,0x00,0x90; mem[0x0080]=0x5A; run FETCH_ADDRESS_1,_2, TEMP_FETCH, FETCH_ADDRESS_3,_4, TEMP_STORE.
  - Required response: TEMP_STORE drives mem_addr=0x0090, mem_we=1, mem_wdata=0x5A; pc advanced by 4.
- STORE: addr_a=0x0100, reg_wdata=0xC3, state STORE_MEMORY -> mem_addr=0x0100, mem_we=1, mem_wdata=0xC3; pc unchanged.
- Wrap and halt:
  - pc=0xFFFF, FETCH_1 -> pc=0x0000.
  - State held at S_HALT for 10 cycles -> pc, instruction and immediate unchanged, mem_we=0 throughout.
